// File: rtl/xorexec_mch_if.sv
// Handshake bundle for xorexec_mch: per-channel input push side and tagged output pop side.
// The opar signal exists only when XOREXEC_MCH_PARITY_EN is defined.
interface xorexec_mch_if #(
   parameter int DWIDTH = 8,
   parameter int NCH    = 2
);
   localparam int CW = $clog2(NCH);

   logic [NCH-1:0]        ififo_push;
   logic [NCH-1:0]        ififo_not_full;
   logic [NCH*DWIDTH-1:0] idata;
   logic                  ofifo_pop;
   logic                  ofifo_rdy;
   logic [DWIDTH-1:0]     odata;
   logic [CW-1:0]         ochan;

`ifdef XOREXEC_MCH_PARITY_EN
   logic                  opar;

   modport master (
      output ififo_push, idata, ofifo_pop,
      input  ififo_not_full, ofifo_rdy, odata, ochan, opar
   );
   modport slave (
      input  ififo_push, idata, ofifo_pop,
      output ififo_not_full, ofifo_rdy, odata, ochan, opar
   );
`else
   modport master (
      output ififo_push, idata, ofifo_pop,
      input  ififo_not_full, ofifo_rdy, odata, ochan
   );
   modport slave (
      input  ififo_push, idata, ofifo_pop,
      output ififo_not_full, ofifo_rdy, odata, ochan
   );
`endif
endinterface

// File: rtl/xorexec_mch.sv
// Multi-channel XOR execution unit: NCH input FIFOs, round-robin arbiter, shared XOR stage, tagged output FIFO.
// Define XOREXEC_MCH_PARITY_EN to store even parity per result and expose it on opar.

module xorexec_mch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         rdy,
   output logic         not_full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign rdy      = (count != '0);
   assign not_full = (count != FULL_CNT);
   assign do_push  = push && not_full;
   assign do_pop   = pop && rdy;
   assign dout     = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage is not reset; contents are qualified by count
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end
endmodule

// state | meaning
// IDLE  | wait for any ready input channel, grant one round-robin, pop and capture its word
// EXEC  | compute operand ^ key (mode 0) or operand ^ acc[chan] (mode 1)
// PUSH  | write {chan, result} into the output FIFO, holding here while it is full
module xorexec_mch #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 8,
   parameter int NCH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   xorexec_mch_if.slave      bus,
   input  logic              mode,
   input  logic [DWIDTH-1:0] key,
   input  logic              acc_clr,
   output logic [2:0]        exec_state,
   output logic              exec_idle
);
   localparam int CW = $clog2(NCH);
`ifdef XOREXEC_MCH_PARITY_EN
   localparam int OW = DWIDTH + CW + 1;
`else
   localparam int OW = DWIDTH + CW;
`endif

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EXEC = 3'd1,
      PUSH = 3'd2
   } state_t;

   state_t            state, state_nx;
   logic [NCH-1:0]    in_pop, in_rdy;
   logic [DWIDTH-1:0] in_dout [NCH];
   logic [CW-1:0]     last_grant, grant, chan;
   logic              any_rdy;
   logic [DWIDTH-1:0] operand, result, exec_val;
   logic [DWIDTH-1:0] acc [NCH];
   logic              out_push, out_not_full;
   logic [OW-1:0]     out_din, out_dout;

   for (genvar c = 0; c < NCH; c++) begin : g_in
      xorexec_mch_fifo #(.W(DWIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (bus.ififo_push[c]),
         .din      (bus.idata[c*DWIDTH +: DWIDTH]),
         .pop      (in_pop[c]),
         .dout     (in_dout[c]),
         .rdy      (in_rdy[c]),
         .not_full (bus.ififo_not_full[c])
      );
   end

   // first ready channel after last_grant, wrapping
   always_comb begin
      int  idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      grant   = '0;
      any_rdy = |in_rdy;
      for (int i = 1; i <= NCH; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && in_rdy[idx]) begin
            grant = CW'(idx);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_pop   = '0;
      out_push = 1'b0;
      case (state)
         IDLE: begin
            if (any_rdy) begin
               in_pop[grant] = 1'b1;
               state_nx      = EXEC;
            end
         end
         EXEC: state_nx = PUSH;
         PUSH: begin
            if (out_not_full) begin
               out_push = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign exec_val = operand ^ (mode ? acc[chan] : key);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= CW'(NCH - 1);
         operand    <= '0;
         chan       <= '0;
         result     <= '0;
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
      end else begin
         if (state == IDLE && any_rdy) begin
            operand    <= in_dout[grant];
            chan       <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) result <= exec_val;
         // a clear wins over a same-cycle accumulate
         if (acc_clr) begin
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
         end else if (state == EXEC && mode) begin
            acc[chan] <= exec_val;
         end
      end
   end

`ifdef XOREXEC_MCH_PARITY_EN
   logic par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                par <= 1'b0;
      else if (state == EXEC) par <= ^exec_val;
   end

   assign out_din  = {par, chan, result};
   assign bus.opar = bus.ofifo_rdy & out_dout[OW-1];
`else
   assign out_din  = {chan, result};
`endif

   xorexec_mch_fifo #(.W(OW), .DEPTH(DEPTH)) u_ofifo (
      .clk      (clk),
      .rst      (rst),
      .push     (out_push),
      .din      (out_din),
      .pop      (bus.ofifo_pop),
      .dout     (out_dout),
      .rdy      (bus.ofifo_rdy),
      .not_full (out_not_full)
   );

   assign bus.odata  = out_dout[DWIDTH-1:0];
   assign bus.ochan  = out_dout[DWIDTH +: CW];
   assign exec_state = state;
   assign exec_idle  = (state == IDLE) && !any_rdy;
endmodule

// File: tb/tb_xorexec_mch.sv
// Bench for xorexec_mch: directed scenarios plus randomized traffic checked against a per-channel queue model.
module tb_xorexec_mch;
   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic       acc_clr;
   logic [7:0] key;
   logic [2:0] exec_state;
   logic       exec_idle;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mq [2][$];
   logic [7:0] macc [2];
   logic [7:0] pd [$];
   logic       pc [$];
   logic [2:0] prev_state;

   xorexec_mch_if #(.DWIDTH(8), .NCH(2)) bus ();

   xorexec_mch #(.DWIDTH(8), .DEPTH(8), .NCH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .mode       (mode),
      .key        (key),
      .acc_clr    (acc_clr),
      .exec_state (exec_state),
      .exec_idle  (exec_idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit legal_step(input logic [2:0] p, input logic [2:0] s);
      return (p == 3'd0 && (s == 3'd0 || s == 3'd1)) ||
             (p == 3'd1 && s == 3'd2) ||
             (p == 3'd2 && (s == 3'd2 || s == 3'd0));
   endfunction

   // model: each channel's words come out in its own push order, transformed by key or running acc
   always @(negedge clk) begin
      if (rst) begin
         mq[0].delete();
         mq[1].delete();
         macc[0]    = 8'h00;
         macc[1]    = 8'h00;
         prev_state = 3'd0;
      end else begin
         check("state_step", {31'd0, legal_step(prev_state, exec_state)}, 1);
         prev_state = exec_state;
         if (acc_clr) begin
            macc[0] = 8'h00;
            macc[1] = 8'h00;
         end
         for (int c = 0; c < 2; c++)
            if (bus.ififo_push[c] && bus.ififo_not_full[c])
               mq[c].push_back(bus.idata[c*8 +: 8]);
         if (bus.ofifo_pop && bus.ofifo_rdy) begin
            int         c;
            logic [7:0] d, e;
            c = int'(bus.ochan);
            if (mq[c].size() == 0) begin
               check("model_underflow", 1, 0);
            end else begin
               d = mq[c].pop_front();
               e = mode ? (d ^ macc[c]) : (d ^ key);
               if (mode) macc[c] = e;
               check("odata", {24'd0, bus.odata}, {24'd0, e});
`ifdef XOREXEC_MCH_PARITY_EN
               check("opar", {31'd0, bus.opar}, {31'd0, ^e});
`endif
            end
            pd.push_back(bus.odata);
            pc.push_back(bus.ochan);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input int c, input logic [7:0] d);
      bus.ififo_push          = 2'(1 << c);
      bus.idata[c*8 +: 8]     = d;
      step();
      bus.ififo_push          = 2'b00;
   endtask

   task automatic drain();
      bus.ififo_push = 2'b00;
      bus.ofifo_pop  = 1'b1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (exec_idle && !bus.ofifo_rdy) break;
      end
      bus.ofifo_pop = 1'b0;
      check("drain_done", {30'd0, exec_idle, bus.ofifo_rdy}, 32'd2);
      check("model_q0_empty", mq[0].size(), 0);
      check("model_q1_empty", mq[1].size(), 0);
   endtask

   task automatic check_pop(input string name, input int idx, input logic [7:0] d, input logic c);
      if (idx < pd.size()) begin
         check({name, "_data"}, {24'd0, pd[idx]}, {24'd0, d});
         check({name, "_chan"}, {31'd0, pc[idx]}, {31'd0, c});
      end else begin
         check({name, "_missing"}, 0, 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst            = 1'b1;
      mode           = 1'b0;
      key            = 8'h00;
      acc_clr        = 1'b0;
      bus.ififo_push = 2'b00;
      bus.idata      = 16'h0000;
      bus.ofifo_pop  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_state", {29'd0, exec_state}, 0);
      check("rst_ofifo_rdy", {31'd0, bus.ofifo_rdy}, 0);
      check("rst_not_full", {30'd0, bus.ififo_not_full}, 32'd3);
      check("rst_exec_idle", {31'd0, exec_idle}, 1);

      // single word latency, mode 0
      key = 8'hFF;
      push_word(0, 8'h5A);
      step();
      check("lat_exec", {29'd0, exec_state}, 1);
      step();
      check("lat_push", {29'd0, exec_state}, 2);
      check("lat_not_yet", {31'd0, bus.ofifo_rdy}, 0);
      step();
      check("lat_rdy", {31'd0, bus.ofifo_rdy}, 1);
      check("lat_odata", {24'd0, bus.odata}, 32'hA5);
      check("lat_ochan", {31'd0, bus.ochan}, 0);
      check("lat_back_idle", {29'd0, exec_state}, 0);
      drain();

      // accumulate on ch1, ch0 acc untouched
      mode    = 1'b1;
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      base = pd.size();
      push_word(1, 8'h01);
      push_word(1, 8'h02);
      push_word(1, 8'h04);
      drain();
      check_pop("acc0", base,     8'h01, 1'b1);
      check_pop("acc1", base + 1, 8'h03, 1'b1);
      check_pop("acc2", base + 2, 8'h07, 1'b1);
      base = pd.size();
      push_word(0, 8'h10);
      drain();
      check_pop("acc_ch0", base, 8'h10, 1'b0);

      // round robin with both channels preloaded
      mode = 1'b0;
      key  = 8'h3C;
      base = pd.size();
      for (int i = 0; i < 4; i++) begin
         bus.ififo_push = 2'b11;
         bus.idata      = 16'($urandom);
         step();
      end
      drain();
      check("rr_count", pd.size() - base, 8);
      for (int i = 1; i < 8; i++)
         if (base + i < pd.size())
            check("rr_alternate", {31'd0, pc[base+i] != pc[base+i-1]}, 1);

      // output full stall, then input full
      base = pd.size();
      for (int i = 0; i < 9; i++) push_word(0, 8'(8'h80 + i));
      repeat (40) step();
      check("stall_state", {29'd0, exec_state}, 2);
      check("stall_ofifo_rdy", {31'd0, bus.ofifo_rdy}, 1);
      for (int i = 0; i < 8; i++) push_word(0, 8'(8'h40 + i));
      check("in_full", {31'd0, bus.ififo_not_full[0]}, 0);
      push_word(0, 8'hEE);
      check("in_full_hold", {31'd0, bus.ififo_not_full[0]}, 0);
      bus.ofifo_pop = 1'b1;
      step();
      bus.ofifo_pop = 1'b0;
      check("pop_one_still_push", {29'd0, exec_state}, 2);
      step();
      check("pop_one_pushed", {29'd0, exec_state}, 0);
      drain();
      check("stall_total", pd.size() - base, 17);

      // reset while executing
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.ififo_push = 2'b11;
         bus.idata      = 16'($urandom);
         step();
      end
      bus.ififo_push = 2'b00;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            if (exec_state == 3'd1) begin
               seen = 1'b1;
               break;
            end
            step();
         end
         check("reach_exec", {31'd0, seen}, 1);
      end
      rst = 1'b1;
      #1;
      check("mid_rst_state", {29'd0, exec_state}, 0);
      check("mid_rst_ofifo_rdy", {31'd0, bus.ofifo_rdy}, 0);
      check("mid_rst_not_full", {30'd0, bus.ififo_not_full}, 32'd3);
      step();
      rst = 1'b0;
      check("post_rst_idle", {31'd0, exec_idle}, 1);
      base = pd.size();
      push_word(1, 8'h33);
      drain();
      check_pop("post_rst_acc", base, 8'h33, 1'b1);

      // randomized traffic phases
      for (int ph = 0; ph < 4; ph++) begin
         mode = (ph % 2) == 1;
         key  = 8'($urandom);
         if (ph == 3) begin
            acc_clr = 1'b1;
            step();
            acc_clr = 1'b0;
         end
         for (int cyc = 0; cyc < 300; cyc++) begin
            bus.ififo_push = 2'($urandom_range(0, 3));
            bus.idata      = 16'($urandom);
            bus.ofifo_pop  = (ph == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            step();
         end
         drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/xorexec_mch.md
# xorexec_mch

Multi-channel, parametrised successor to the single-channel XOR execution top level. NCH independent input FIFOs feed one shared XOR execution unit via a round-robin arbiter; results, tagged with their source channel, land in a single output FIFO. Per-channel operation is either XOR with a shared key or a running XOR accumulate. It sits between upstream producers and one downstream consumer, with the same push/not_full and pop/rdy handshakes as the existing exec top level.

## Interface
- DWIDTH, 8, data width in bits (≥1)
- DEPTH, 8, entries per FIFO; power of two, ≥2
- NCH, 2, number of input channels (≥2); CW = $clog2(NCH)

- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ififo_push  input  NCH  per-channel push; honoured only when that channel's not_full is 1
- ififo_not_full  output  NCH  per-channel space available
- idata  input  NCH*DWIDTH  channel c at [c*DWIDTH +: DWIDTH]
- mode  input  1  0: result = data ^ key; 1: result = data ^ acc[c], acc[c] <= result
- key  input  DWIDTH  XOR key for mode 0
- acc_clr  input  1  synchronous clear of all acc[] to 0
- ofifo_pop  input  1  pop; honoured only when ofifo_rdy is 1
- ofifo_rdy  output  1  output FIFO non-empty
- odata  output  DWIDTH  show-ahead head data
- ochan  output  CW  source channel of head entry
- exec_state  output  3  FSM state
- exec_idle  output  1  (exec_state == IDLE) && no input FIFO rdy

## Operation
- FIFOs: show-ahead; dout = mem[rptr]; rdy = count != 0; not_full = count != DEPTH; pointers wrap mod DEPTH; count width $clog2(DEPTH)+1.
- Push when full: ignored, no state change. Pop when empty: ignored. Push and pop in same cycle, not empty and not full: both happen, count unchanged. Push on empty plus pop: pop ignored.
- FSM encoding: IDLE=3'd0, EXEC=3'd1, PUSH=3'd2; other codes unreachable and map to IDLE.
- IDLE: if any input FIFO rdy, grant g = first rdy channel searching from last_grant+1 upward with wrap; pop FIFO g; capture operand <= dout[g], chan <= g, last_grant <= g; go to EXEC. Otherwise stay.
- EXEC: sample mode and key; result <= operand ^ (mode ? acc[chan] : key); in mode 1 acc[chan] <= same value; go to PUSH.
- PUSH: if output FIFO not_full, push {chan, result}; go to IDLE. Otherwise hold in PUSH, with result held stable.
- acc_clr: takes priority over the EXEC accumulate write in the same cycle.
- Reset values: all FIFO pointers and counts 0; ififo_not_full all 1; ofifo_rdy 0; odata/ochan reflect mem[0] (don't care); exec_state IDLE; last_grant NCH-1, so ch0 wins first; acc[] 0; operand/result 0; exec_idle 1.
- Reset mid-operation: the in-flight word and all FIFO contents are discarded, with no partial push.

## Timing
- Input write at edge N → rdy after N → captured at N+1 → computed at N+2 → pushed at N+3 → ofifo_rdy high after N+3. Minimum latency is 3 cycles.
- Throughput: one word per 3 cycles while the output has space. Each PUSH stall cycle adds 1.
- Round-robin: with all channels continuously ready, grants rotate 0,1,…,NCH-1,0.
- ofifo_pop at edge M: the next entry appears on odata/ochan after M.

## Configuration
- XOREXEC_MCH_PARITY_EN defined: output FIFO width grows by 1 and stores even parity (^result), exposed on an extra output port opar (1 bit, reset 0). A 1-bit parity register is added to the result stage.
- XOREXEC_MCH_PARITY_EN undefined: opar port and parity storage are absent. Behaviour is otherwise identical.

## Test plan
- NCH=2, DWIDTH=8, mode=0, key=8'hFF: push 8'h5A on ch0 → after 3 cycles odata=8'hA5, ochan=0, ofifo_rdy=1.
- mode=1: push 8'h01, 8'h02, 8'h04 on ch1 after acc_clr → odata sequence 8'h01, 8'h03, 8'h07, ochan=1; ch0 acc stays 0.
- Both channels preloaded with 4 words each and the output drained continuously → ochan alternates 0,1,0,1…, and exec_state cycles 0→1→2.
- ofifo_pop held 0 with DEPTH=8 → after 8 results the FSM sits in PUSH and exec_state=2. Then pop once → the 9th entry is pushed the next cycle.
- Fill ch0 with 8 words while the exec unit is stalled → ififo_not_full[0]=0, and a 9th push is ignored (count stays 8, data unchanged).
- Assert rst while in EXEC with entries queued → immediately exec_state=0, ofifo_rdy=0, ififo_not_full all 1, acc 0. After deassertion, a new push completes normally.
